// File: rtl/usr_pkg.sv
// usr_pkg: shared select encodings, FSM states and default width for the shift-register sequencer
package usr_pkg;
  localparam int USR_WIDTH = 4;
  localparam logic [1:0] SEL_HOLD = 2'h0;
  localparam logic [1:0] SEL_SHR = 2'h1;
  localparam logic [1:0] SEL_SHL = 2'h2;
  localparam logic [1:0] SEL_LOAD = 2'h3;
  typedef enum logic {ST_IDLE, ST_SHIFT} state_e;
endpackage

// File: rtl/usr_hold_buf.sv
// usr_hold_buf: one-entry holding register for {msb_first, data}; push and pop never coincide
module usr_hold_buf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             msb_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             msb_o,
  output logic [WIDTH-1:0] data_o
);
  logic             full_q;
  logic             msb_q;
  logic [WIDTH-1:0] data_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      msb_q  <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= push_i ? 1'b1 : pop_i ? 1'b0 : full_q;
      msb_q  <= push_i ? msb_i : msb_q;
      data_q <= push_i ? data_i : data_q;
    end
  end
  assign full_o = full_q;
  assign msb_o  = msb_q;
  assign data_o = data_q;
endmodule

// File: rtl/usr_ser_ctrl.sv
// usr_ser_ctrl: drives a universal shift register as a handshaked parallel-to-serial transmitter
module usr_ser_ctrl
  import usr_pkg::*;
#(
  parameter int   WIDTH    = USR_WIDTH,
  parameter logic FILL_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb_first,
  output logic             in_ready,
  output logic [1:0]       sr_select,
  output logic [WIDTH-1:0] sr_p_din,
  output logic             sr_s_left_din,
  output logic             sr_s_right_din,
  input  logic             sr_s_left_dout,
  input  logic             sr_s_right_dout,
  output logic             ser_bit,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_e          state_q, state_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic            dir_q, dir_d;
  logic            buf_full, buf_msb, load, shift, last;
  assign in_ready       = !buf_full && !rst;
  assign sr_s_left_din  = FILL_BIT;
  assign sr_s_right_din = FILL_BIT;
  assign last           = idx_q == LAST;
  usr_hold_buf #(.WIDTH(WIDTH)) u_buf (
    .clk    (clk),
    .rst    (rst),
    .push_i (in_valid && in_ready),
    .msb_i  (in_msb_first),
    .data_i (in_data),
    .pop_i  (load),
    .full_o (buf_full),
    .msb_o  (buf_msb),
    .data_o (sr_p_din)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
    end
  end
  // a load both starts a frame from IDLE and chains the next frame with no bubble
  always_comb begin
    load    = buf_full && (state_q == ST_IDLE || (ser_ready && last));
    shift   = state_q == ST_SHIFT && ser_ready && !last;
    state_d = load ? ST_SHIFT : (state_q == ST_SHIFT && ser_ready && last) ? ST_IDLE : state_q;
    idx_d   = load ? '0 : shift ? idx_q + 1'b1 : idx_q;
    dir_d   = load ? buf_msb : dir_q;
  end
  always_comb begin
    ser_valid   = !rst && state_q == ST_SHIFT;
    ser_bit     = dir_q ? sr_s_right_dout : sr_s_left_dout;
    frame_start = ser_valid && idx_q == '0;
    frame_end   = ser_valid && last;
    busy        = !rst && (state_q == ST_SHIFT || buf_full);
    sr_select   = rst ? SEL_HOLD : load ? SEL_LOAD : shift ? (dir_q ? SEL_SHL : SEL_SHR) : SEL_HOLD;
  end
endmodule

// File: tb/tb_usr_ser_ctrl.sv
// tb_usr_ser_ctrl: scoreboard bench with a universal shift register model and a bit-order reference
module tb_usr_ser_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_msb_first = 1'b0;
  logic       in_ready;
  logic [1:0] sr_select;
  logic [3:0] sr_p_din;
  logic       sr_s_left_din, sr_s_right_din;
  logic       ser_bit, ser_valid, frame_start, frame_end, busy;
  logic       ser_ready = 1'b1;
  logic       sr_rst_n = 1'b0;
  logic [3:0] sr_q;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         rnd_on = 1'b0;

  typedef struct {logic b; logic fs; logic fe;} exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  // universal shift register: sync active-low reset, right shift fills MSB, left shift fills LSB
  always @(posedge clk) begin
    if (!sr_rst_n) sr_q <= 4'h0;
    else if (sr_select == 2'd1) sr_q <= {sr_s_right_din, sr_q[3:1]};
    else if (sr_select == 2'd2) sr_q <= {sr_q[2:0], sr_s_left_din};
    else if (sr_select == 2'd3) sr_q <= sr_p_din;
  end

  usr_ser_ctrl #(.WIDTH(4), .FILL_BIT(1'b0)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_msb_first    (in_msb_first),
    .in_ready        (in_ready),
    .sr_select       (sr_select),
    .sr_p_din        (sr_p_din),
    .sr_s_left_din   (sr_s_left_din),
    .sr_s_right_din  (sr_s_right_din),
    .sr_s_left_dout  (sr_q[0]),
    .sr_s_right_dout (sr_q[3]),
    .ser_bit         (ser_bit),
    .ser_valid       (ser_valid),
    .ser_ready       (ser_ready),
    .frame_start     (frame_start),
    .frame_end       (frame_end),
    .busy            (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [3:0] d, input logic m);
    in_valid = 1'b1;
    in_data = d;
    in_msb_first = m;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("accept_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    logic done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      done = !busy && !ser_valid;
    end
    chk("idle_timeout", done, 1'b1);
    @(posedge clk);
    #1;
  endtask

  // monitor: accepted words become expected bit streams; consumed bits are popped and compared
  initial begin
    exp_t e;
    logic prev_stall = 1'b0;
    logic pb = 1'b0, pfs = 1'b0, pfe = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        prev_stall = 1'b0;
      end else begin
        if (in_valid && in_ready)
          for (int i = 0; i < 4; i++) begin
            e.b = in_msb_first ? in_data[3-i] : in_data[i];
            e.fs = (i == 0);
            e.fe = (i == 3);
            exp_q.push_back(e);
          end
        if (prev_stall) chk("stall_stable", {ser_valid, ser_bit, frame_start, frame_end}, {1'b1, pb, pfs, pfe});
        if (ser_valid && ser_ready) begin
          if (exp_q.size() == 0) chk("extra_bit", 1'b1, 1'b0);
          else begin
            e = exp_q.pop_front();
            chk("ser_bit", ser_bit, e.b);
            chk("frame_flags", {frame_start, frame_end}, {e.fs, e.fe});
          end
        end
        prev_stall = ser_valid && !ser_ready;
        pb = ser_bit;
        pfs = frame_start;
        pfe = frame_end;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1 if (rnd_on) ser_ready = $urandom_range(0, 3) != 0;
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_outputs", {ser_valid, frame_start, frame_end, busy, sr_select}, 6'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    sr_rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    // single word LSB first with latency check
    send(4'b1101, 1'b0);
    @(negedge clk);
    chk("lat_load_sel", sr_select, 2'd3);
    chk("lat_load_valid", ser_valid, 1'b0);
    @(negedge clk);
    chk("lat_first_valid", {ser_valid, frame_start}, 2'b11);
    wait_idle();
    // single word MSB first: three left shifts then hold
    send(4'b1101, 1'b1);
    @(negedge clk);
    chk("msb_load_sel", sr_select, 2'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("msb_shl_sel", sr_select, 2'd2);
    end
    @(negedge clk);
    chk("msb_last_sel", sr_select, 2'd0);
    wait_idle();
    // back-to-back: 8 consecutive valid bits, load on last bit of the first word
    send(4'hA, 1'b0);
    send(4'h3, 1'b1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("b2b_valid", ser_valid, 1'b1);
      if (i == 2) chk("b2b_chain_sel", {sr_select, frame_end}, 3'b111);
    end
    @(negedge clk);
    chk("b2b_done", ser_valid, 1'b0);
    wait_idle();
    // backpressure after first bit of 4'h6
    send(4'h6, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 ser_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold", {sr_select, ser_valid, ser_bit}, 4'b0011);
    end
    @(posedge clk);
    #1 ser_ready = 1'b1;
    wait_idle();
    // buffer full: third word must wait
    send(4'h5, 1'b0);
    send(4'h9, 1'b1);
    @(negedge clk);
    chk("full_in_ready", {in_ready, busy}, 2'b01);
    @(posedge clk);
    #1;
    send(4'hC, 1'b0);
    wait_idle();
    // reset mid-frame
    send(4'hF, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_out", {ser_valid, sr_select, in_ready}, 4'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    send(4'h1, 1'b0);
    wait_idle();
    chk("midrst_drained", exp_q.size(), 0);
    // randomized streaming with random backpressure
    rnd_on = 1'b1;
    for (int w = 0; w < 40; w++) begin
      send(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
    end
    rnd_on = 1'b0;
    @(posedge clk);
    #2 ser_ready = 1'b1;
    wait_idle();
    chk("final_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
